bt_press_encoder: RTL and testbench

Input-side conditioner for the four active-low board push-buttons. Synchronises and debounces `V_BT`, then detects a clean single-button press. Each press becomes a 2-bit button code and is delivered over a valid/ready handshake to the display path, which renders the code on the seven-segment digit. An optional counter tallies accepted presses for the LED bar.

---
 rtl/bt_pkg.sv | 26 ++
 rtl/bt_debounce.sv | 47 ++++
 rtl/bt_press_encoder.sv | 108 ++++++++++
 tb/tb_bt_press_encoder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bt_pkg.sv
// Shared types and helpers for the push-button press encoder.
package bt_pkg;

  localparam int BT_N   = 4;
  localparam int CODE_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_HELD  = 2'd2
  } bt_state_e;

  function automatic logic is_one_hot(input logic [BT_N-1:0] v);
    return (v != '0) && ((v & (v - BT_N'(1))) == '0);
  endfunction

  function automatic logic [CODE_W-1:0] onehot_to_code(input logic [BT_N-1:0] v);
    logic [CODE_W-1:0] c;
    c = '0;
    for (int i = 0; i < BT_N; i++) begin
      if (v[i]) c = CODE_W'(i);
    end
    return c;
  endfunction

endpackage

// File: rtl/bt_debounce.sv
// One button: 2-flop synchroniser, inversion to active-high, and a
// run-length debounce counter that toggles the stable level.
module bt_debounce
  import bt_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw_n,
  output logic o_stable
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          w_sample;

  assign w_sample = ~r_sync2;
  assign o_stable = r_stable;

  // Synchroniser resets to 1 so a released button reads as released.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_raw_n;
      r_sync2 <= r_sync1;
      if (w_sample == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_stable <= ~r_stable;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/bt_press_encoder.sv
// Debounces four active-low buttons and emits a single-button press code over
// valid/ready. Optional press counter built when BT_PRESS_COUNT_EN is defined.
module bt_press_encoder
  import bt_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 4
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic [3:0]       V_BT,
  output logic [3:0]       BT_STABLE,
  output logic             PRESS_VALID,
  output logic [1:0]       PRESS_CODE,
  input  logic             PRESS_READY,
  output logic             PRESS_OVF,
  output logic [CNT_W-1:0] PRESS_COUNT
);

  // Handshake: a transfer happens on any cycle with PRESS_VALID && PRESS_READY;
  // valid and code hold until then, and READY is ignored while VALID is low.

  logic [BT_N-1:0]   w_stable;
  bt_state_e         r_state;
  bt_state_e         w_next;
  logic              w_issue;
  logic              w_xfer;
  logic [CODE_W-1:0] r_pend_code;
  logic              r_valid;
  logic [CODE_W-1:0] r_code;
  logic              r_ovf;

  for (genvar g = 0; g < BT_N; g++) begin : g_btn
    bt_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk     (CLOCK_50),
      .rst     (RESET),
      .i_raw_n (V_BT[g]),
      .o_stable(w_stable[g])
    );
  end

  assign BT_STABLE   = w_stable;
  assign PRESS_VALID = r_valid;
  assign PRESS_CODE  = r_code;
  assign PRESS_OVF   = r_ovf;
  assign w_xfer      = r_valid & PRESS_READY;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (is_one_hot(w_stable))  w_next = ST_PRESS;
        else if (w_stable != '0)   w_next = ST_HELD;
      end
      ST_PRESS: w_next = ST_HELD;
      ST_HELD:  if (w_stable == '0) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_issue = (r_state == ST_PRESS);
  end

  // Code is captured on the IDLE cycle that decides the press.
  always_ff @(posedge CLOCK_50) begin
    if (RESET)                   r_pend_code <= '0;
    else if (r_state == ST_IDLE) r_pend_code <= onehot_to_code(w_stable);
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_valid <= 1'b0;
      r_code  <= '0;
      r_ovf   <= 1'b0;
    end else if (w_issue) begin
      if (!r_valid || w_xfer) begin
        r_valid <= 1'b1;
        r_code  <= r_pend_code;
      end else begin
        r_ovf <= 1'b1;
      end
    end else if (w_xfer) begin
      r_valid <= 1'b0;
    end
  end

`ifdef BT_PRESS_COUNT_EN
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge CLOCK_50) begin
    if (RESET)       r_count <= '0;
    else if (w_xfer) r_count <= r_count + CNT_W'(1);
  end

  assign PRESS_COUNT = r_count;
`else
  assign PRESS_COUNT = '0;
`endif

endmodule

// File: tb/tb_bt_press_encoder.sv
// Bench for bt_press_encoder: directed vector table, corner sequences and
// randomized buttons checked every cycle against a reference model.
module tb_bt_press_encoder;

  localparam int D  = 4;
  localparam int CW = 4;
`ifdef BT_PRESS_COUNT_EN
  localparam bit COUNT_EN = 1'b1;
`else
  localparam bit COUNT_EN = 1'b0;
`endif

  logic          CLOCK_50 = 1'b0;
  logic          RESET = 1'b1;
  logic [3:0]    V_BT = 4'hF;
  logic          PRESS_READY = 1'b0;
  logic [3:0]    BT_STABLE;
  logic          PRESS_VALID;
  logic [1:0]    PRESS_CODE;
  logic          PRESS_OVF;
  logic [CW-1:0] PRESS_COUNT;

  bt_press_encoder #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (CW)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .RESET      (RESET),
    .V_BT       (V_BT),
    .BT_STABLE  (BT_STABLE),
    .PRESS_VALID(PRESS_VALID),
    .PRESS_CODE (PRESS_CODE),
    .PRESS_READY(PRESS_READY),
    .PRESS_OVF  (PRESS_OVF),
    .PRESS_COUNT(PRESS_COUNT)
  );

  // ---------------- clock ----------------
  always #5 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Stable level flips after D consecutive synchronised samples disagree with it.
  // An event is born when the stable set goes from empty to a single button and
  // becomes visible two cycles later; it is dropped if the slot is still full.
  logic [3:0]    m_s1, m_s2, m_stable, m_prev, m_sample;
  int            m_run [4];
  bit            m_issue, m_trig, m_xfer;
  logic [1:0]    m_issue_code;
  logic          m_valid, m_ovf;
  logic [1:0]    m_code;
  logic [CW-1:0] m_count;
  bit            model_on = 1'b0;

  always @(posedge CLOCK_50) begin
    if (RESET) begin
      m_s1 = 4'hF; m_s2 = 4'hF; m_stable = 4'h0; m_prev = 4'h0;
      for (int n = 0; n < 4; n++) m_run[n] = 0;
      m_issue = 1'b0; m_issue_code = 2'd0;
      m_valid = 1'b0; m_ovf = 1'b0; m_code = 2'd0; m_count = '0;
    end else begin
      m_xfer = m_valid && PRESS_READY;
      if (m_xfer) m_count = m_count + 1'b1;
      if (m_issue) begin
        if (!m_valid || m_xfer) begin
          m_valid = 1'b1;
          m_code  = m_issue_code;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (m_xfer) begin
        m_valid = 1'b0;
      end
      m_trig = (m_prev == 4'h0) && ($countones(m_stable) == 1);
      m_issue = m_trig;
      if (m_trig) begin
        for (int n = 0; n < 4; n++) if (m_stable[n]) m_issue_code = 2'(n);
      end
      m_prev   = m_stable;
      m_sample = ~m_s2;
      m_s2     = m_s1;
      m_s1     = V_BT;
      for (int n = 0; n < 4; n++) begin
        if (m_sample[n] == m_stable[n]) begin
          m_run[n] = 0;
        end else begin
          m_run[n]++;
          if (m_run[n] == D) begin
            m_stable[n] = ~m_stable[n];
            m_run[n] = 0;
          end
        end
      end
    end
  end

  // ---------------- scoreboard: every cycle vs model ----------------
  logic [31:0] exp_q[$];

  always @(negedge CLOCK_50) begin
    if (model_on) begin
      exp_q.push_back({19'd0, m_stable, m_valid, m_code, m_ovf, (COUNT_EN ? m_count : {CW{1'b0}})});
      check("model", {19'd0, BT_STABLE, PRESS_VALID, PRESS_CODE, PRESS_OVF, PRESS_COUNT},
            exp_q.pop_front());
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0]    v;
    logic          rdy;
    int            cyc;
    logic [3:0]    st;
    logic          vld;
    logic [1:0]    code;
    logic          ovf;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t tbl [20];

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic apply_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      V_BT        = tbl[i].v;
      PRESS_READY = tbl[i].rdy;
      wait_cyc(tbl[i].cyc);
      check($sformatf("row%0d_stable", i), 32'(BT_STABLE), 32'(tbl[i].st));
      check($sformatf("row%0d_valid", i), 32'(PRESS_VALID), 32'(tbl[i].vld));
      check($sformatf("row%0d_code", i), 32'(PRESS_CODE), 32'(tbl[i].code));
      check($sformatf("row%0d_ovf", i), 32'(PRESS_OVF), 32'(tbl[i].ovf));
      check($sformatf("row%0d_count", i), 32'(PRESS_COUNT),
            32'(COUNT_EN ? tbl[i].cnt : {CW{1'b0}}));
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, {25'd0, BT_STABLE, PRESS_VALID, PRESS_CODE, PRESS_OVF}, 32'd0);
    check({name, "_count"}, 32'(PRESS_COUNT), 32'd0);
  endtask

  logic [CW-1:0] exp_cnt;

  initial begin
    // single button 2, ready high
    tbl[0]  = '{4'b1011, 1'b1, 5,  4'b0000, 1'b0, 2'd0, 1'b0, 4'd0};
    tbl[1]  = '{4'b1011, 1'b1, 1,  4'b0100, 1'b0, 2'd0, 1'b0, 4'd0};
    tbl[2]  = '{4'b1011, 1'b1, 1,  4'b0100, 1'b0, 2'd0, 1'b0, 4'd0};
    tbl[3]  = '{4'b1011, 1'b1, 1,  4'b0100, 1'b1, 2'd2, 1'b0, 4'd0};
    tbl[4]  = '{4'b1011, 1'b1, 1,  4'b0100, 1'b0, 2'd2, 1'b0, 4'd1};
    tbl[5]  = '{4'b1111, 1'b1, 6,  4'b0000, 1'b0, 2'd2, 1'b0, 4'd1};
    tbl[6]  = '{4'b1011, 1'b1, 8,  4'b0100, 1'b1, 2'd2, 1'b0, 4'd1};
    tbl[7]  = '{4'b1011, 1'b1, 1,  4'b0100, 1'b0, 2'd2, 1'b0, 4'd2};
    tbl[8]  = '{4'b1111, 1'b1, 6,  4'b0000, 1'b0, 2'd2, 1'b0, 4'd2};
    // back-pressure and overflow
    tbl[9]  = '{4'b1101, 1'b0, 8,  4'b0010, 1'b1, 2'd1, 1'b0, 4'd2};
    tbl[10] = '{4'b1101, 1'b0, 50, 4'b0010, 1'b1, 2'd1, 1'b0, 4'd2};
    tbl[11] = '{4'b1111, 1'b0, 6,  4'b0000, 1'b1, 2'd1, 1'b0, 4'd2};
    tbl[12] = '{4'b0111, 1'b0, 8,  4'b1000, 1'b1, 2'd1, 1'b1, 4'd2};
    tbl[13] = '{4'b0111, 1'b1, 1,  4'b1000, 1'b0, 2'd1, 1'b1, 4'd3};
    tbl[14] = '{4'b1111, 1'b0, 6,  4'b0000, 1'b0, 2'd1, 1'b1, 4'd3};
    // multi-press
    tbl[15] = '{4'b1100, 1'b0, 10, 4'b0011, 1'b0, 2'd1, 1'b1, 4'd3};
    tbl[16] = '{4'b1111, 1'b0, 6,  4'b0000, 1'b0, 2'd1, 1'b1, 4'd3};
    tbl[17] = '{4'b1110, 1'b1, 8,  4'b0001, 1'b1, 2'd0, 1'b1, 4'd3};
    tbl[18] = '{4'b0110, 1'b1, 10, 4'b1001, 1'b0, 2'd0, 1'b1, 4'd4};
    tbl[19] = '{4'b1111, 1'b1, 6,  4'b0000, 1'b0, 2'd0, 1'b1, 4'd4};

    // reset and idle
    RESET = 1'b1;
    wait_cyc(2);
    RESET = 1'b0;
    model_on = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wait_cyc(1);
      check_all_zero("idle");
    end

    apply_rows(0, 8);

    // glitching button 0 never settles long enough
    for (int i = 0; i < 15; i++) begin
      V_BT = (i % 2 == 1) ? 4'b1111 : 4'b1110;
      for (int k = 0; k < 2; k++) begin
        wait_cyc(1);
        check("glitch_stable", 32'(BT_STABLE), 32'd0);
        check("glitch_valid", 32'(PRESS_VALID), 32'd0);
      end
    end
    V_BT = 4'b1111;
    wait_cyc(10);
    check("glitch_end_stable", 32'(BT_STABLE), 32'd0);

    apply_rows(9, 19);

    // counter wrap over 16 transfers
    exp_cnt = 4'd4;
    PRESS_READY = 1'b1;
    for (int k = 0; k < 16; k++) begin
      V_BT = 4'b1110;
      wait_cyc(9);
      exp_cnt = exp_cnt + 1'b1;
      check("wrap_count", 32'(PRESS_COUNT), 32'(COUNT_EN ? exp_cnt : {CW{1'b0}}));
      V_BT = 4'b1111;
      wait_cyc(6);
    end

    // reset with an event pending
    PRESS_READY = 1'b0;
    V_BT = 4'b1011;
    wait_cyc(8);
    check("pre_reset_valid", 32'(PRESS_VALID), 32'd1);
    RESET = 1'b1;
    wait_cyc(1);
    check_all_zero("after_reset");
    RESET = 1'b0;
    V_BT = 4'b1111;
    wait_cyc(10);

    // randomized buttons, ready and occasional reset
    for (int it = 0; it < 300; it++) begin
      V_BT = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      for (int k = 0; k < int'($urandom_range(1, 15)); k++) begin
        PRESS_READY = 1'($urandom_range(0, 1));
        RESET = ($urandom_range(0, 150) == 0);
        wait_cyc(1);
      end
      RESET = 1'b0;
    end
    V_BT = 4'hF;
    wait_cyc(12);
    model_on = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
